iic_arbiter: RTL



---
 rtl/iic_arb_pkg.sv | 21 ++
 rtl/iic_arbiter_rr_arbiter.sv | 33 +++
 rtl/iic_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/iic_arb_pkg.sv
// Shared state encoding and constants for the IIC bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iic_arb_pkg;

    localparam int ARB_DATA_W     = 16;
    localparam int START_LOST_CYC = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/iic_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; gnt_vld low when nothing is requesting.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [PW:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
            if (!gnt_vld && req[cand[PW-1:0]]) begin
                gnt[cand[PW-1:0]] = 1'b1;
                gnt_idx           = cand[PW-1:0];
                gnt_vld           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin share of one iic_drive between REQ_NUM clients; IIC_ARB_RETRY_EN adds ack-error retries.
// Latency: grant 1 cycle after cli_req seen in IDLE; cli_done 1 cycle after iic_ready returns.
// Backpressure: clients hold cli_req until cli_done; start waits for iic_ready, watchdog aborts stuck transfers.
module iic_arbiter
    import iic_arb_pkg::*;
#(
    parameter int          REQ_NUM     = 2,
    parameter int          DATA_W      = ARB_DATA_W,
    parameter logic [27:0] TIMEOUT_CYC = 28'd2_000_000,
    parameter int          RETRY_MAX   = 2
) (
    input  logic                      iic_clk,
    input  logic                      iic_rst_n,
    input  logic [REQ_NUM-1:0]        cli_req,
    input  logic [REQ_NUM-1:0]        cli_rw_flag,
    input  logic [8*REQ_NUM-1:0]      cli_word_addr,
    input  logic [DATA_W*REQ_NUM-1:0] cli_wdata,
    output logic [REQ_NUM-1:0]        cli_grant,
    output logic [REQ_NUM-1:0]        cli_done,
    output logic [REQ_NUM-1:0]        cli_err,
    output logic [DATA_W-1:0]         cli_rdata,
    output logic                      iic_start,
    input  logic                      iic_ready,
    output logic                      iic_rw_flag,
    output logic [7:0]                iic_word_addr,
    output logic [DATA_W-1:0]         iic_wdata,
    input  logic [DATA_W-1:0]         iic_rdata,
    input  logic                      iic_rdata_valid,
    input  logic                      iic_ack_error
);

    localparam int          PW        = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int          LW        = $clog2(START_LOST_CYC);
    localparam logic [LW-1:0] LOST_LAST = LW'(START_LOST_CYC - 1);

    arb_state_t          state_q, state_d;
    logic [REQ_NUM-1:0]  grant_q, grant_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                err_q, err_d;
    logic [27:0]         to_cnt_q, to_cnt_d;
    logic [LW-1:0]       lost_cnt_q, lost_cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [REQ_NUM-1:0]  pick;
    logic [PW-1:0]       pick_idx;
    logic                pick_vld;
    logic                waiting;
    logic                to_hit;
    logic                retry;

    rr_arbiter #(
        .N  (REQ_NUM),
        .PW (PW)
    ) u_rr (
        .req     (cli_req),
        .ptr     (ptr_q),
        .gnt     (pick),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign waiting   = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
    // Counter is cleared at start, so it reads k-1 in the k-th cycle after the start pulse.
    assign to_hit    = (to_cnt_q == TIMEOUT_CYC - 28'd2);
    assign cli_grant = grant_q;
    assign cli_rdata = rdata_q;

`ifdef IIC_ARB_RETRY_EN
    localparam int RW = $clog2(RETRY_MAX + 2);
    logic [RW-1:0] retry_q;
    logic          tmo_q;

    always_ff @(posedge iic_clk or negedge iic_rst_n) begin
        if (!iic_rst_n) begin
            retry_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (iic_start)
                tmo_q <= 1'b0;
            else if (waiting && to_hit)
                tmo_q <= 1'b1;
            if (state_q == ST_IDLE)
                retry_q <= '0;
            else if (retry)
                retry_q <= retry_q + 1'b1;
        end
    end

    // Timeouts are final; only ack errors earn another attempt.
    assign retry = (state_q == ST_RESP) && err_q && !tmo_q && (retry_q < RW'(RETRY_MAX));
`else
    assign retry = 1'b0;
`endif

    always_ff @(posedge iic_clk or negedge iic_rst_n) begin
        if (!iic_rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
            lost_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;
        lost_cnt_d = lost_cnt_q;
        rdata_d    = rdata_q;
        iic_start  = 1'b0;
        cli_done   = '0;
        cli_err    = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (iic_ready) begin
                    iic_start  = 1'b1;
                    err_d      = 1'b0;
                    to_cnt_d   = '0;
                    lost_cnt_d = '0;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!iic_ready)
                    state_d = ST_WAIT_DONE;
                else if (lost_cnt_q == LOST_LAST)
                    state_d = ST_LAUNCH;
                else
                    lost_cnt_d = lost_cnt_q + 1'b1;
            end
            ST_WAIT_DONE: begin
                if (iic_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (retry) begin
                    state_d = ST_LAUNCH;
                end else begin
                    cli_done = grant_q;
                    cli_err  = err_q ? grant_q : '0;
                    grant_d  = '0;
                    ptr_d    = PW'(wrap_inc(int'(owner_q), REQ_NUM));
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An ack error coinciding with the ready rise still lands in err_q on the RESP edge.
        if (waiting) begin
            to_cnt_d = to_cnt_q + 28'd1;
            if (iic_ack_error)   err_d   = 1'b1;
            if (iic_rdata_valid) rdata_d = iic_rdata;
            if (to_hit) begin
                err_d   = 1'b1;
                state_d = ST_RESP;
            end
        end
    end

    always_comb begin
        iic_rw_flag   = 1'b0;
        iic_word_addr = '0;
        iic_wdata     = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant_q[i]) begin
                iic_rw_flag   = cli_rw_flag[i];
                iic_word_addr = cli_word_addr[i*8 +: 8];
                iic_wdata     = cli_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
